// File: rtl/decode_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode_queue_if : fetch-side and execute-side handshake of decode_queue     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface decode_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_ra;
  logic [4:0]      out_rb;
  logic [4:0]      out_rd;
  logic [2:0]      out_alu_ctr;
  logic            out_alu_ext;
  logic [1:0]      out_alu_sela;
  logic [1:0]      out_alu_selb;
  logic            out_mem_wr;
  logic            out_mem_load;
  logic            out_mem_signed;
  logic            out_reg_wr;
  logic [2:0]      out_mem_opt;
  logic [2:0]      out_branch;
  logic            out_muldiv;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_ra, out_rb, out_rd,
           out_alu_ctr, out_alu_ext, out_alu_sela, out_alu_selb, out_mem_wr,
           out_mem_load, out_mem_signed, out_reg_wr, out_mem_opt, out_branch,
           out_muldiv, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_ra, out_rb, out_rd,
           out_alu_ctr, out_alu_ext, out_alu_sela, out_alu_selb, out_mem_wr,
           out_mem_load, out_mem_signed, out_reg_wr, out_mem_opt, out_branch,
           out_muldiv, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode_queue : RV32I/M decoder feeding a FIFO of decoded bundles            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int HAS_M = 1
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     flush_i,
  decode_queue_if.slave                 q_if,
  output logic [$clog2(DEPTH):0]        count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;

  localparam logic [1:0] ALU_A_REG  = 2'b00;
  localparam logic [1:0] ALU_A_PC   = 2'b01;
  localparam logic [1:0] ALU_A_ZERO = 2'b10;
  localparam logic [1:0] ALU_B_REG  = 2'b00;
  localparam logic [1:0] ALU_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_B_FOUR = 2'b10;

  localparam logic [2:0] BRANCH_NONE = 3'b000;
  localparam logic [2:0] BRANCH_JAL  = 3'b001;
  localparam logic [2:0] BRANCH_JALR = 3'b010;
  localparam logic [2:0] BRANCH_BEQ  = 3'b100;
  localparam logic [2:0] BRANCH_BNE  = 3'b101;
  localparam logic [2:0] BRANCH_BLT  = 3'b110;
  localparam logic [2:0] BRANCH_BGE  = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      ra;
    logic [4:0]      rb;
    logic [4:0]      rd;
    logic [2:0]      alu_ctr;
    logic            alu_ext;
    logic [1:0]      sela;
    logic [1:0]      selb;
    logic            mem_wr;
    logic            mem_load;
    logic            mem_signed;
    logic            reg_wr;
    logic [2:0]      mem_opt;
    logic [2:0]      branch;
    logic            muldiv;
    logic            illegal;
  } bundle_t;

  logic [XLEN-1:0] w_inst;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [2:0]      w_mask;
  bundle_t         w_dec;
  logic            w_bad;

  assign w_inst = q_if.in_inst;
  assign w_op   = w_inst[6:0];
  assign w_f3   = w_inst[14:12];
  assign w_f7   = w_inst[31:25];

  always_comb begin
    case (w_f3[1:0])
      2'b00:   w_mask = 3'b001;
      2'b01:   w_mask = 3'b011;
      2'b10:   w_mask = 3'b111;
      default: w_mask = 3'b000;
    endcase
  end

  always_comb begin
    w_dec         = '0;
    w_bad         = 1'b0;
    w_dec.pc      = q_if.in_pc;
    w_dec.ra      = w_inst[19:15];
    w_dec.rb      = w_inst[24:20];
    w_dec.rd      = w_inst[11:7];
    w_dec.alu_ctr = ALU_ADD;
    w_dec.sela    = ALU_A_REG;
    w_dec.selb    = ALU_B_REG;
    w_dec.branch  = BRANCH_NONE;
    case (w_op)
      OP_LUI: begin
        w_dec.imm    = {w_inst[31:12], 12'b0};
        w_dec.sela   = ALU_A_ZERO;
        w_dec.selb   = ALU_B_IMM;
        w_dec.reg_wr = 1'b1;
      end
      OP_AUIPC: begin
        w_dec.imm    = {w_inst[31:12], 12'b0};
        w_dec.sela   = ALU_A_PC;
        w_dec.selb   = ALU_B_IMM;
        w_dec.reg_wr = 1'b1;
      end
      OP_JAL: begin
        w_dec.imm    = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
        w_dec.sela   = ALU_A_PC;
        w_dec.selb   = ALU_B_FOUR;
        w_dec.reg_wr = 1'b1;
        w_dec.branch = BRANCH_JAL;
      end
      OP_JALR: begin
        w_dec.imm    = {{20{w_inst[31]}}, w_inst[31:20]};
        w_dec.sela   = ALU_A_PC;
        w_dec.selb   = ALU_B_FOUR;
        w_dec.reg_wr = 1'b1;
        w_dec.branch = BRANCH_JALR;
      end
      OP_BR: begin
        w_dec.imm     = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
        w_dec.alu_ctr = (w_f3[2:1] == 2'b11) ? ALU_SLTU : ALU_SLT;
        case (w_f3)
          3'b000:         w_dec.branch = BRANCH_BEQ;
          3'b001:         w_dec.branch = BRANCH_BNE;
          3'b100, 3'b110: w_dec.branch = BRANCH_BLT;
          3'b101, 3'b111: w_dec.branch = BRANCH_BGE;
          default:        w_bad        = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_dec.imm        = {{20{w_inst[31]}}, w_inst[31:20]};
        w_dec.selb       = ALU_B_IMM;
        w_dec.reg_wr     = 1'b1;
        w_dec.mem_load   = 1'b1;
        w_dec.mem_signed = ~w_f3[2];
        w_dec.mem_opt    = w_mask;
        w_bad            = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OP_STORE: begin
        w_dec.imm     = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
        w_dec.selb    = ALU_B_IMM;
        w_dec.mem_wr  = 1'b1;
        w_dec.mem_opt = w_mask;
        w_bad         = (w_f3 > 3'b010);
      end
      OP_IMM: begin
        w_dec.imm     = {{20{w_inst[31]}}, w_inst[31:20]};
        w_dec.selb    = ALU_B_IMM;
        w_dec.reg_wr  = 1'b1;
        w_dec.alu_ctr = w_f3;
        w_dec.alu_ext = (w_f3 == 3'b101) && w_inst[30];
      end
      OP_REG: begin
        w_dec.reg_wr  = 1'b1;
        w_dec.alu_ctr = w_f3;
        w_dec.alu_ext = w_inst[30];
        // funct7=0100000 only qualifies SUB and SRA; 0000001 is MUL/DIV when enabled
        if ((HAS_M != 0) && (w_f7 == 7'b0000001)) begin
          w_dec.muldiv = 1'b1;
        end else if (!((w_f7 == 7'b0000000) ||
                       ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))))) begin
          w_bad = 1'b1;
        end
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_dec.reg_wr = 1'b0;
      w_dec.mem_wr = 1'b0;
      w_dec.branch = BRANCH_NONE;
    end
    w_dec.illegal = w_bad;
  end

  bundle_t         mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            w_push;
  logic            w_pop;
  bundle_t         w_head;

  assign q_if.in_ready  = (count_q < FULL_CNT) && !flush_i;
  assign q_if.out_valid = (count_q != '0);
  assign w_push         = q_if.in_valid && q_if.in_ready;
  assign w_pop          = q_if.out_valid && q_if.out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) tail_d = tail_q + 1'b1;
      if (w_pop)  head_d = head_q + 1'b1;
      if (w_push && !w_pop)      count_d = count_q + 1'b1;
      else if (!w_push && w_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an empty queue masks the head to zero.
  always_ff @(posedge clk) begin
    if (!rst && w_push) mem_q[tail_q] <= w_dec;
  end

  assign w_head = q_if.out_valid ? mem_q[head_q] : '0;

  assign q_if.out_pc         = w_head.pc;
  assign q_if.out_imm        = w_head.imm;
  assign q_if.out_ra         = w_head.ra;
  assign q_if.out_rb         = w_head.rb;
  assign q_if.out_rd         = w_head.rd;
  assign q_if.out_alu_ctr    = w_head.alu_ctr;
  assign q_if.out_alu_ext    = w_head.alu_ext;
  assign q_if.out_alu_sela   = w_head.sela;
  assign q_if.out_alu_selb   = w_head.selb;
  assign q_if.out_mem_wr     = w_head.mem_wr;
  assign q_if.out_mem_load   = w_head.mem_load;
  assign q_if.out_mem_signed = w_head.mem_signed;
  assign q_if.out_reg_wr     = w_head.reg_wr;
  assign q_if.out_mem_opt    = w_head.mem_opt;
  assign q_if.out_branch     = w_head.branch;
  assign q_if.out_muldiv     = w_head.muldiv;
  assign q_if.out_illegal    = w_head.illegal;
  assign count_o             = count_q;
endmodule
`default_nettype wire

// File: doc/decode_queue.md
# decode_queue

Registered, parametrised RV32I/M decode stage with a valid/ready handshake on both sides and an internal FIFO of decoded bundles. It sits between instruction fetch and execute: fetch pushes raw instructions with their PC, and execute pops fully decoded control bundles. It extends the combinational decoder in three ways: it adds M-extension and illegal-instruction decoding, it adds flush support, and it buffers decoded bundles for back-pressure.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is legal.
- `DEPTH`, 2, FIFO entries; a power of two, at least 2.
- `HAS_M`, 1, decode the M extension. When 0, M-encoded instructions are treated as illegal.

Ports:
- `clk`  in  1  clock. Everything in the block is clocked on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all queued bundles and any push in the same cycle.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  the queue can accept an instruction.
- `in_inst`  in  XLEN  raw instruction.
- `in_pc`  in  XLEN  PC of the instruction.
- `out_valid`  out  1  the head bundle is valid.
- `out_ready`  in  1  execute consumes the head bundle.
- `out_pc`, `out_imm`  out  XLEN  PC and sign-extended immediate.
- `out_ra`, `out_rb`, `out_rd`  out  5  register numbers, taken from inst[19:15], inst[24:20] and inst[11:7].
- `out_alu_ctr`  out  3  ALU operation.
- `out_alu_ext`  out  1  ALU variant.
- `out_alu_sela`, `out_alu_selb`  out  2  ALU operand selects (`ALU_A_*` / `ALU_B_*`).
- `out_mem_wr`, `out_mem_load`, `out_mem_signed`, `out_reg_wr`  out  1  memory and register-file control.
- `out_mem_opt`  out  3  byte mask: 001 = byte, 011 = half, 111 = word.
- `out_branch`  out  3  `BRANCH_*` code.
- `out_muldiv`  out  1  the instruction is an M-extension op; `out_alu_ctr` then carries funct3.
- `out_illegal`  out  1  the opcode, funct3 or funct7 is unsupported.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation

**Combinational decode of `in_inst`**
- Immediates are decoded per format: I/L, S, B, U (LUI/AUIPC), J. JALR uses the I-format immediate. All other formats give 0.
- ALU control:
  - R/I types: `alu_ctr` = funct3 and `alu_ext` = inst[30]. For I-type, `alu_ext` is inst[30] only when funct3=101; otherwise it is 0.
  - B type: `ALU_SLTU` when funct3[2:1]=11, else `ALU_SLT`.
  - All others: `ALU_ADD`.
- Operand selects:
  - `sela`: PC for AUIPC/JAL/JALR, ZERO for LUI, REG otherwise.
  - `selb`: FOUR for JAL/JALR, IMM for S/L/I/LUI/AUIPC, REG otherwise.
- `reg_wr` is 1 for L, R, I, LUI, AUIPC, JAL and JALR.
- `mem_signed` is 1 for L with funct3[2]=0.
- `mem_opt` is 000 unless the instruction is S or L.
- Branch codes:
  - `BRANCH_NONE` by default.
  - JAL and JALR give their own codes.
  - B type: BEQ, BNE, BLT (for BLT/BLTU) and BGE (for BGE/BGEU).
- `muldiv` is 1 for opcode R with funct7=0000001 when HAS_M=1.
- Illegal instructions:
  - Conditions: an unknown opcode, inst[1:0]≠11, an S funct3 above 010, an L funct3 of 011/110/111, or a B funct3 of 010/011.
  - An illegal bundle is still enqueued, with `reg_wr`=`mem_wr`=0 and branch NONE.

**FIFO**
- The decoded bundle plus `in_pc` is written at the tail on a push, which occurs when `in_valid && in_ready`.
- A pop occurs when `out_valid && out_ready` and advances the head.
- `in_ready` = (count < DEPTH) && !flush.
- `out_valid` = (count != 0).
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- Push and pop in the same cycle leave `count` unchanged. This is legal when count is between 1 and DEPTH-1. When full, `in_ready` is 0, so no push happens.
- When empty, all `out_*` data outputs read 0.

**Priority and state**
- Priority order: `rst` first, then `flush`, then push/pop.
- `flush` sets count, head and tail to 0 on the next edge and ignores any pop or push in that cycle.
- `rst`, including mid-stream, clears count and the pointers. After reset:
  - `in_ready`=1.
  - `out_valid`=0.
  - All `out_*` fields and `count` are 0.
- There is no explicit state machine. State consists of {head, tail, count}.

## Timing
- Latency is one cycle: an instruction pushed at edge N is visible on `out_*` with `out_valid`=1 after edge N. There is no same-cycle bypass.
- Throughput is one bundle per cycle, sustained when `out_ready`=1 continuously and DEPTH≥2.
- `in_ready` depends only on registered count and on `flush`. It has no combinational path from `out_ready`.
- Output fields are read from registered storage; the only combinational step is the head mux.

## Test plan
- **Reset and single push.** Reset, then push 0x00500093 (addi x1,x0,5) at PC 0x100. The next cycle must show:
  - `out_valid`=1, `out_pc`=0x100, `out_imm`=5, `out_rd`=1, `out_reg_wr`=1, `out_alu_selb`=`ALU_B_IMM`.
- **Load word.** Push 0xFFC0A103 (lw x2,-4(x1)). Required:
  - `out_imm`=0xFFFFFFFC, `out_mem_load`=1, `out_mem_opt`=111, `out_mem_signed`=1, `out_ra`=1, `out_rd`=2.
- **Branch.** Push 0x00208463 (beq x1,x2,8). Required:
  - `out_imm`=8, `out_branch`=`BRANCH_BEQ`, `out_alu_ctr`=`ALU_SLT`, `out_reg_wr`=0.
- **M extension.** Push 0x022081B3 (mul x3,x1,x2).
  - With HAS_M=1: `out_muldiv`=1, `out_rd`=3, `out_illegal`=0.
  - With HAS_M=0: `out_illegal`=1, `out_reg_wr`=0.
- **Back-pressure.** Set DEPTH=4 and hold `out_ready`=0 while pushing 5 instructions. Required:
  - `count`=4 and `in_ready`=0 after the 4th push.
  - Then raise `out_ready`: bundles drain in order, and the 5th instruction enters one cycle after the first pop.
- **Flush.** With `count`=3, assert `flush` together with `in_valid`. Required:
  - The next cycle shows `count`=0, `out_valid`=0 and all `out_*`=0.
  - The simultaneous push is dropped.
